// File: rtl/sr_pkg.sv
// Shared constants and arbitration helper for the SR flip-flop command path.
// The debounce defaults are also used by the flip-flop's top-level wrapper.
package sr_pkg;

  localparam int SR_DEBOUNCE_DEFAULT = 4;
  localparam int SR_CNT_W            = 8;

  typedef enum logic [1:0] {
    ARB_NONE,
    ARB_SET,
    ARB_CLR,
    ARB_CONFLICT
  } sr_arb_e;

  // Coincident edges are dropped so that s and r can never be driven together.
  function automatic sr_arb_e sr_arbitrate(input logic set_rise, input logic clr_rise);
    sr_arb_e outcome;
    outcome = ARB_NONE;
    if (set_rise && clr_rise) begin
      outcome = ARB_CONFLICT;
    end else if (set_rise) begin
      outcome = ARB_SET;
    end else if (clr_rise) begin
      outcome = ARB_CLR;
    end
    return outcome;
  endfunction

endpackage

// File: rtl/sr_debounce.sv
// One request channel: 2-flop synchroniser, debounce counter, debounced level
// and rising-edge detect of that level.
module sr_debounce
  import sr_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = SR_DEBOUNCE_DEFAULT,
  parameter int CNT_W           = SR_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_in,
  output logic lvl,
  output logic rise
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_q1;
  logic             sync_q2;
  logic             lvl_prev;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= raw_in;
      sync_q2 <= sync_q1;
    end
  end

  // The level only flips after DEBOUNCE_CYCLES consecutive mismatching samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvl      <= 1'b0;
      lvl_prev <= 1'b0;
      cnt      <= '0;
    end else begin
      lvl_prev <= lvl;
      if (sync_q2 == lvl) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        lvl <= sync_q2;
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign rise = lvl & ~lvl_prev;

endmodule

// File: rtl/sr_cmd_gen.sv
// Command stage for the SR flip-flop: debounces the raw set/clear requests and
// turns their rising edges into mutually exclusive one-cycle s/r pulses.
module sr_cmd_gen
  import sr_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = SR_DEBOUNCE_DEFAULT,
  parameter int CNT_W           = SR_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic set_in,
  input  logic clr_in,
  output logic s,
  output logic r,
  output logic set_lvl,
  output logic clr_lvl,
  output logic conflict
);

  logic    set_rise;
  logic    clr_rise;
  sr_arb_e arb;

  sr_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_set_deb (
    .clk    (clk),
    .rst_n  (rst_n),
    .raw_in (set_in),
    .lvl    (set_lvl),
    .rise   (set_rise)
  );

  sr_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_clr_deb (
    .clk    (clk),
    .rst_n  (rst_n),
    .raw_in (clr_in),
    .lvl    (clr_lvl),
    .rise   (clr_rise)
  );

  always_comb begin
    arb = sr_arbitrate(set_rise, clr_rise);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s        <= 1'b0;
      r        <= 1'b0;
      conflict <= 1'b0;
    end else begin
      s        <= (arb == ARB_SET);
      r        <= (arb == ARB_CLR);
      conflict <= (arb == ARB_CONFLICT);
    end
  end

endmodule

// File: tb/tb_sr_cmd_gen.sv
// Self-checking bench for sr_cmd_gen: a window-based debounce model checked
// every cycle, plus literal expectations at hand-computed edges.
module tb_sr_cmd_gen;
  import sr_pkg::*;

  localparam int N = 4;

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic set_in = 1'b0;
  logic clr_in = 1'b0;
  logic s, r, set_lvl, clr_lvl, conflict;

  int checks    = 0;
  int errors    = 0;
  int edge_no   = 0;
  int s_pulses  = 0;
  int r_pulses  = 0;
  int cf_pulses = 0;

  // model state
  logic [15:0] hist_s = '0;
  logic [15:0] hist_c = '0;
  bit lvl_s = 0, lvl_c = 0, rise_s = 0, rise_c = 0;
  bit exp_s = 0, exp_r = 0, exp_cf = 0;

  sr_cmd_gen #(
    .DEBOUNCE_CYCLES (N),
    .CNT_W           (SR_CNT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_in   (set_in),
    .clr_in   (clr_in),
    .s        (s),
    .r        (r),
    .set_lvl  (set_lvl),
    .clr_lvl  (clr_lvl),
    .conflict (conflict)
  );

  initial forever #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    edge_no++;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at edge %0d: got %0d expected %0d", name, edge_no, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic set_v, input logic clr_v);
    set_in = set_v;
    clr_in = clr_v;
  endtask

  // Returns 3 time units after rising edge n, after the compare process has run.
  task automatic wait_edge(input int n);
    while (edge_no < n) begin
      @(posedge clk);
      #1;
    end
    #2;
  endtask

  // A level flips once the last N synchronised samples (raw samples 2..N+1 edges old) all disagree with it.
  function automatic bit window_flips(input logic [15:0] h, input bit lvl);
    for (int i = 2; i <= N + 1; i++) begin
      if (h[i] == lvl) return 1'b0;
    end
    return 1'b1;
  endfunction

  initial forever begin
    bit new_s, new_c;
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      hist_s = '0; hist_c = '0;
      lvl_s = 0; lvl_c = 0; rise_s = 0; rise_c = 0;
      exp_s = 0; exp_r = 0; exp_cf = 0;
    end else begin
      exp_s  = rise_s && !rise_c;
      exp_r  = rise_c && !rise_s;
      exp_cf = rise_s && rise_c;
      hist_s = {hist_s[14:0], set_in};
      hist_c = {hist_c[14:0], clr_in};
      new_s  = window_flips(hist_s, lvl_s) ? !lvl_s : lvl_s;
      new_c  = window_flips(hist_c, lvl_c) ? !lvl_c : lvl_c;
      rise_s = new_s && !lvl_s;
      rise_c = new_c && !lvl_c;
      lvl_s  = new_s;
      lvl_c  = new_c;
    end
  end

  initial forever begin
    @(posedge clk);
    #2;
    checkOutput("s", s, exp_s);
    checkOutput("r", r, exp_r);
    checkOutput("conflict", conflict, exp_cf);
    checkOutput("set_lvl", set_lvl, lvl_s);
    checkOutput("clr_lvl", clr_lvl, lvl_c);
    checkOutput("s_r_exclusive", s & r, 0);
    if (s === 1'b1) s_pulses++;
    if (r === 1'b1) r_pulses++;
    if (conflict === 1'b1) cf_pulses++;
  end

  initial begin
    int s_mark, r_mark, cf_mark;
    $display("[TB] start, DEBOUNCE_CYCLES=%0d", N);
    applyStimulus(1'b0, 1'b0);
    #2;
    checkOutput("reset_s", s, 0);
    checkOutput("reset_r", r, 0);
    checkOutput("reset_conflict", conflict, 0);
    checkOutput("reset_set_lvl", set_lvl, 0);
    wait_edge(2);
    rst_n = 1'b1;

    // single set request, then held 50 cycles, low 10, high again
    wait_edge(9);
    applyStimulus(1'b1, 1'b0);
    wait_edge(14); checkOutput("t1_set_lvl_e14", set_lvl, 0);
    wait_edge(15); checkOutput("t1_set_lvl_e15", set_lvl, 1);
                   checkOutput("t1_s_e15", s, 0);
    wait_edge(16); checkOutput("t1_s_e16", s, 1);
                   checkOutput("t1_r_e16", r, 0);
    wait_edge(17); checkOutput("t1_s_e17", s, 0);
    wait_edge(59);
    checkOutput("held_one_pulse", s_pulses, 1);
    applyStimulus(1'b0, 1'b0);
    wait_edge(64); checkOutput("fall_lvl_e64", set_lvl, 1);
    wait_edge(65); checkOutput("fall_lvl_e65", set_lvl, 0);
    wait_edge(69);
    applyStimulus(1'b1, 1'b0);
    wait_edge(75); checkOutput("repress_lvl_e75", set_lvl, 1);
    wait_edge(76); checkOutput("repress_s_e76", s, 1);
    wait_edge(80);
    checkOutput("held_two_pulses", s_pulses, 2);
    checkOutput("held_no_r", r_pulses, 0);
    applyStimulus(1'b0, 1'b0);

    // clear bounce: high 3, low 1, high 2, low
    wait_edge(90);
    r_mark = r_pulses;
    applyStimulus(1'b0, 1'b1);
    wait_edge(93); applyStimulus(1'b0, 1'b0);
    wait_edge(94); applyStimulus(1'b0, 1'b1);
    wait_edge(96); applyStimulus(1'b0, 1'b0);
    wait_edge(100); checkOutput("bounce_clr_lvl", clr_lvl, 0);
    wait_edge(108);
    checkOutput("bounce_no_r", r_pulses - r_mark, 0);

    // simultaneous rise
    wait_edge(110);
    s_mark = s_pulses; r_mark = r_pulses; cf_mark = cf_pulses;
    applyStimulus(1'b1, 1'b1);
    wait_edge(117); checkOutput("sim_conflict_e117", conflict, 1);
                    checkOutput("sim_s_e117", s, 0);
                    checkOutput("sim_r_e117", r, 0);
    wait_edge(118); checkOutput("sim_conflict_e118", conflict, 0);
    wait_edge(125);
    checkOutput("sim_no_s", s_pulses - s_mark, 0);
    checkOutput("sim_no_r", r_pulses - r_mark, 0);
    checkOutput("sim_one_conflict", cf_pulses - cf_mark, 1);
    applyStimulus(1'b0, 1'b0);

    // back-to-back: clear one cycle after set
    wait_edge(140);
    cf_mark = cf_pulses;
    applyStimulus(1'b1, 1'b0);
    wait_edge(141); applyStimulus(1'b1, 1'b1);
    wait_edge(147); checkOutput("b2b_s_e147", s, 1);
                    checkOutput("b2b_r_e147", r, 0);
    wait_edge(148); checkOutput("b2b_s_e148", s, 0);
                    checkOutput("b2b_r_e148", r, 1);
    wait_edge(155);
    checkOutput("b2b_no_conflict", cf_pulses - cf_mark, 0);
    applyStimulus(1'b0, 1'b0);

    // reset in the middle of debouncing a set request
    wait_edge(170);
    s_mark = s_pulses;
    applyStimulus(1'b1, 1'b0);
    wait_edge(172);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_async_set_lvl", set_lvl, 0);
    wait_edge(175);
    checkOutput("rst_no_pulse", s_pulses - s_mark, 0);
    rst_n = 1'b1;
    wait_edge(180); checkOutput("rst_lvl_e180", set_lvl, 0);
    wait_edge(181); checkOutput("rst_lvl_e181", set_lvl, 1);
                    checkOutput("rst_s_e181", s, 0);
    wait_edge(182); checkOutput("rst_s_e182", s, 1);
    wait_edge(190);
    checkOutput("rst_one_pulse", s_pulses - s_mark, 1);

    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sr_cmd_gen.md
# sr_cmd_gen

Upstream command stage for the SR flip-flop. Takes two raw, asynchronous level inputs (set request, clear request), synchronises and debounces each, detects the rising edge of each debounced level and emits one-cycle `s` / `r` pulses that drive the flip-flop's `s` and `r` inputs directly. The block guarantees that `s` and `r` are never high together; simultaneous requests are dropped and flagged.

## Interface

- `DEBOUNCE_CYCLES`, default 4. Consecutive cycles a synchronised input must differ from its debounced level before that level flips. Legal range 1..255.
- `CNT_W`, default 8. Width of the per-channel debounce counter. Must hold `DEBOUNCE_CYCLES-1`.

- `clk` input 1. Single clock, rising-edge.
- `rst_n` input 1. Asynchronous, active-low reset.
- `set_in` input 1. Raw set request, asynchronous to `clk`.
- `clr_in` input 1. Raw clear request, asynchronous to `clk`.
- `s` output 1. One-cycle set pulse to the flip-flop.
- `r` output 1. One-cycle reset pulse to the flip-flop.
- `set_lvl` output 1. Debounced `set_in` level.
- `clr_lvl` output 1. Debounced `clr_in` level.
- `conflict` output 1. One-cycle pulse when set and clear edges coincide.

## Operation

- Per channel: 2-flop synchroniser, then debounce, then rising-edge detect.
- Debounce:
  - When the synchronised value equals the debounced level, the counter clears to 0.
  - When it differs and the counter equals `DEBOUNCE_CYCLES-1`, the debounced level takes the synchronised value and the counter clears.
  - Otherwise, on a mismatch, the counter increments.
- Edge: `rise` is true when the debounced level is 1 and its previous-cycle copy is 0. Falling edges produce no pulse.
- Arbitration, registered, with exactly one outcome per cycle:
  - Set rise only: `s`=1.
  - Clear rise only: `r`=1.
  - Both rise in the same cycle: `s`=0, `r`=0, `conflict`=1.
  - Neither: all three outputs 0.
- Invariant: `s` and `r` are never both 1, in any cycle, including the first cycle after reset release.
- A glitch or bounce lasting fewer than `DEBOUNCE_CYCLES` synchronised cycles produces no level change and no pulse.
- A held input produces exactly one pulse. A new pulse requires the debounced level to fall and then rise again.

## Timing

- Reset values: `s`, `r`, `set_lvl`, `clr_lvl` and `conflict` are 0. Synchroniser flops, debounced levels, previous-level copies and counters are all 0.
- Latency: let `set_in` be stable high before clock edge k.
  - Synchroniser output is 1 after edge k+1.
  - `set_lvl` rises after edge k+1+N, where N is `DEBOUNCE_CYCLES`.
  - `s` is high for exactly one cycle after edge k+2+N.
  - With the default N=4, this is 6 edges. The clear channel is identical.
- `set_lvl` / `clr_lvl` fall with the same k+1+N latency and produce no output pulse.
- Reset asserted mid-operation clears everything immediately, independent of `clk`, and aborts any pulse in progress.
- After reset release, an input held high counts as a fresh rising edge. It pulses after N+2 edges.
- Channels are independent. Edges one cycle apart give `s` and `r` pulses on consecutive cycles with no conflict.

## Structure

- Shared package `sr_pkg`:
  - `SR_DEBOUNCE_DEFAULT` = 4.
  - `SR_CNT_W` = 8.
  - These are also used by the flip-flop's top-level wrapper.
- Sub-module `sr_debounce`: synchroniser, counter, debounced level and rise output. It is instantiated twice, once for set and once for clear.
- The top level holds only the arbitration registers.

## Test plan

- Reset then stimulus, N=4: `set_in` rises before edge 10 and stays high → `set_lvl`=1 after edge 15, `s`=1 only in the cycle after edge 16, `r` and `conflict` stay 0.
- Bounce, N=4: `clr_in` toggles high 3 cycles, low 1, high 2, low → no `clr_lvl` change, `r` never asserted.
- Simultaneous: `set_in` and `clr_in` rise before the same edge → `conflict`=1 for one cycle, `s`=`r`=0 throughout.
- Back-to-back: `clr_in` rises one cycle after `set_in` → `s` pulse then `r` pulse on the next cycle, no conflict.
- Reset mid-debounce: `set_in` high, `rst_n` asserted 2 cycles after the rise, released 3 cycles later with `set_in` still high → no pulse before reset, one `s` pulse N+2 edges after the first edge following release.
- Held input plus release/repress: `set_in` high 50 cycles, low 10, high again → exactly two `s` pulses, with `set_lvl` tracking at N+1 latency.
